// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and decode helpers for the load/store memory adapter.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MRG  = 3'd2,
        WR   = 3'd3,
        RSP  = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned widths exist only for loads; a store with funct3[2] set is illegal.
    function automatic logic lsu_illegal_f3(input logic [2:0] f3, input logic we);
        logic ill;
        case (f3)
            F3_B, F3_H, F3_W: ill = 1'b0;
            F3_BU, F3_HU:     ill = we;
            default:          ill = 1'b1;
        endcase
        return ill;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Force the low address bits onto the natural lane boundary of the access size.
    function automatic logic [1:0] lsu_align_lo(input logic [2:0] f3, input logic [1:0] lo);
        logic [1:0] al;
        case (f3[1:0])
            2'b01:   al = {lo[1], 1'b0};
            2'b10:   al = 2'b00;
            default: al = lo;
        endcase
        return al;
    endfunction

endpackage

// File: rtl/lsu_mem_adapter_if.sv
// Request/response and data-memory signals between the execute stage, the adapter and the memory.
interface lsu_mem_adapter_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    logic [XLEN-1:0] mem_addr;
    logic            mem_r_enable;
    logic            mem_w_enable;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    // Adapter side.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_r_enable, mem_w_enable, mem_wdata
    );

    // Execute stage plus memory side.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_r_enable, mem_w_enable, mem_wdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge into an old memory word.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] old_word_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] load_data_c_o,
    output logic [XLEN-1:0] merged_word_c_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = old_word_i[{addr_lo_i, 3'b000} +: 8];
        half_lane = old_word_i[{addr_lo_i[1], 4'b0000} +: 16];
    end

    // Sign- or zero-extend the selected lane according to funct3.
    always_comb begin
        load_data_c_o = old_word_i;
        case (funct3_i)
            F3_B:    load_data_c_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_BU:   load_data_c_o = {{(XLEN-8){1'b0}}, byte_lane};
            F3_H:    load_data_c_o = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_HU:   load_data_c_o = {{(XLEN-16){1'b0}}, half_lane};
            default: load_data_c_o = old_word_i;
        endcase
    end

    // Replace only the addressed lane of the old word with the low bits of the store data.
    always_comb begin
        merged_word_c_o = old_word_i;
        case (funct3_i[1:0])
            2'b00:   merged_word_c_o[{addr_lo_i, 3'b000} +: 8]       = store_data_i[7:0];
            2'b01:   merged_word_c_o[{addr_lo_i[1], 4'b0000} +: 16] = store_data_i[15:0];
            default: merged_word_c_o = store_data_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_adapter.sv
// RV32I load/store to word-memory adapter with read-modify-write for sub-word stores.
// Build option: define LSU_MISALIGN_ERR_EN to report misaligned H/W accesses as errors
// instead of silently aligning them.
module lsu_mem_adapter
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_mem_adapter_if.slave   bus
);

    localparam longint unsigned MEM_BYTES = 64'(MEM_WORDS) * 64'd4;

    lsu_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [2:0]      f3_q, f3_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            req_err_c;
    logic            req_sw_c;
    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] merged_word_c;

    // Request decode is only consumed in IDLE; it steers state, never the memory strobes directly.
    always_comb begin
        req_err_c = lsu_illegal_f3(bus.req_funct3, bus.req_we)
                  || (64'(bus.req_addr) >= MEM_BYTES);
`ifdef LSU_MISALIGN_ERR_EN
        req_err_c = req_err_c || lsu_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`endif
        req_sw_c  = bus.req_we && (bus.req_funct3[1:0] == 2'b10);
    end

    lsu_lane_align #(
        .XLEN (XLEN)
    ) u_lane_align (
        .old_word_i      (bus.mem_rdata),
        .store_data_i    (wdata_q),
        .addr_lo_i       (addr_q[1:0]),
        .funct3_i        (f3_q),
        .load_data_c_o   (load_data_c),
        .merged_word_c_o (merged_word_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err_c) begin
                        state_d = RSP;
                    end else if (req_sw_c) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = MRG;
            MRG:     state_d = we_q ? WR : RSP;
            WR:      state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and handshake are pure decodes of the state register.
    always_comb begin
        bus.req_ready    = (state_q == IDLE);
        bus.mem_r_enable = (state_q == RD);
        bus.mem_w_enable = (state_q == WR);
        bus.resp_valid   = (state_q == RSP);
        bus.mem_addr     = '0;
        if ((state_q == RD) || (state_q == WR)) begin
            bus.mem_addr = {addr_q[XLEN-1:2], 2'b00};
        end
        bus.mem_wdata    = wdata_q;
        bus.resp_rdata   = rdata_q;
        bus.resp_err     = err_q;
    end

    // Response registers only change on the edge that enters RSP, so they hold between responses.
    always_comb begin
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = {bus.req_addr[XLEN-1:2],
                               lsu_align_lo(bus.req_funct3, bus.req_addr[1:0])};
                    f3_d    = bus.req_funct3;
                    we_d    = bus.req_we;
                    wdata_d = bus.req_wdata;
                    if (req_err_c) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            MRG: begin
                if (we_q) begin
                    wdata_d = merged_word_c;
                end else begin
                    rdata_d = load_data_c;
                    err_d   = 1'b0;
                end
            end
            WR: begin
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            f3_q    <= 3'b000;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/lsu_mem_adapter.md
Name: lsu_mem_adapter

Overview:
- Load/store unit that sits directly upstream of the core's word-addressed data memory.
- Converts RV32I byte, halfword and word loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into whole-word memory accesses.
- Sub-word stores are done as read-modify-write; load data is extracted and sign- or zero-extended.
- Presents a single-outstanding valid/ready request port to the execute stage and a one-cycle response pulse back.

Parameters:
- XLEN, 32, data and address width.
- MEM_WORDS, 4096, depth of the data memory in 32-bit words. Byte addresses at or above MEM_WORDS*4 are out of range.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data; the low byte/halfword is used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse for both loads and stores.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid: illegal funct3, out-of-range address, or misaligned access.
- mem_addr  out  XLEN  word-aligned byte address (bits [1:0] = 0).
- mem_r_enable  out  1  memory read strobe.
- mem_w_enable  out  1  memory write strobe.
- mem_wdata  out  XLEN  full word to write.
- mem_rdata  in  XLEN  registered memory read data, valid the cycle after mem_r_enable.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0 except req_ready, which is 1.
  - The latched request is cleared.
  - Reset during RD, MRG or WR abandons the operation; no further memory strobe is issued.
- All outputs are registered or decoded from the state register only; there is no combinational path from req_* to mem_*.
- States:
  - IDLE: accept a request and latch addr/funct3/we/wdata. Next state:
    - error -> RSP
    - SW -> WR
    - any load, SB or SH -> RD
  - RD: mem_r_enable=1, mem_addr={addr[31:2],2'b00}. Next state MRG.
  - MRG: mem_rdata is valid.
    - Load: extract the lane (byte by addr[1:0], halfword by addr[1]), extend per funct3, register into resp_rdata; next state RSP.
    - SB/SH: merge the store lane into mem_rdata, register into mem_wdata; next state WR.
  - WR: mem_w_enable=1, mem_wdata holds the full word (SW: req_wdata; SB/SH: merged word). Next state RSP.
  - RSP: resp_valid=1 for exactly one cycle. Next state IDLE.
- mem_r_enable and mem_w_enable are never high in the same cycle.
- Latency, counted from the acceptance edge to the resp_valid cycle:
  - load: 3 cycles
  - SW: 2 cycles
  - SB/SH: 4 cycles
  - error: 1 cycle
- There is no response backpressure. req_ready is 0 from acceptance until the cycle after RSP.
- Errors:
  - Illegal funct3 (011, 110, 111, or 1xx with req_we=1) -> resp_err=1.
  - addr >= MEM_WORDS*4 -> resp_err=1.
  - On any error, no memory strobe is issued.
- resp_rdata and resp_err hold their values until the next RSP.

Optional Feature:
- LSU_MISALIGN_ERR_EN defined: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0, gives resp_err=1 and no memory access.
- LSU_MISALIGN_ERR_EN undefined: misaligned low address bits are forced to lane alignment (cleared to 0 for W, addr[0] cleared for H) and the access proceeds normally; resp_err is not set for misalignment.

Decomposition:
- Package lsu_pkg holds:
  - enum lsu_state_e {IDLE, RD, MRG, WR, RSP}
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
  - function lsu_illegal_f3
- One combinational sub-module, lsu_lane_align, provides:
  - the load extract/extend path
  - the store merge path (old word, new data, addr[1:0], size)
  - both reused by the FSM

Test Plan:
- SW addr 0x100 data 0x11223344 -> one mem_w_enable cycle with mem_addr 0x100; resp_valid 2 cycles after acceptance, resp_err=0.
- After the SW above, LB 0x101 -> resp_rdata 0x00000033; LBU 0x103 -> 0x00000011; each resp_valid 3 cycles after acceptance.
- SB 0x102 data 0x000000AB -> RD, MRG, WR with mem_wdata 0x11AB3344; a following LW 0x100 returns 0x11AB3344.
- SH 0x100 data 0x8001, then LH 0x100 -> 0xFFFF8001; LHU 0x100 -> 0x00008001.
- LW 0x102 with LSU_MISALIGN_ERR_EN -> resp_err=1 one cycle after acceptance, no strobes.
  - Same request without the macro -> reads word 0x100.
  - Any request with addr 0x4000 -> resp_err=1.
- Pull rst_n low during MRG of an SB -> outputs go to 0 immediately (req_ready=1), mem_w_enable never asserts, and the memory word is unchanged on readback.
